// File: rtl/video_color_pkg.sv
// BT.601 colour-conversion constants shared by the RGB->YCbCr and YCbCr->RGB datapaths.
// Coefficients are 9-bit signed; accumulations are 18-bit signed.
package video_color_pkg;

    localparam int SUM_W = 18;

    // Row-major: Y, Cb, Cr rows; R, G, B columns.
    localparam logic signed [8:0] COEF [9] = '{
        9'sd66,   9'sd129,  9'sd25,
        -9'sd38,  -9'sd74,  9'sd112,
        9'sd112,  -9'sd94,  -9'sd18
    };

    localparam logic signed [SUM_W-1:0] ROUND_BIAS = 18'sd128;

    localparam int Y_OFFSET     = 16;
    localparam int C_OFFSET     = 128;
    localparam int STUDIO_LO    = 16;
    localparam int STUDIO_Y_HI  = 235;
    localparam int STUDIO_C_HI  = 240;
    localparam int FULL_LO      = 0;
    localparam int FULL_HI      = 255;
    localparam int PIPE_LATENCY = 4;

    function automatic int clamp_lo(bit studio);
        return studio ? STUDIO_LO : FULL_LO;
    endfunction

    function automatic int clamp_hi(bit studio, bit chroma);
        if (!studio)
            return FULL_HI;
        return chroma ? STUDIO_C_HI : STUDIO_Y_HI;
    endfunction

endpackage

// File: rtl/color_clamp8.sv
// Turns one 18-bit rounded colour sum into an 8-bit component:
// floor shift by 8, add the component offset, clamp to [LO, HI].
module color_clamp8
    import video_color_pkg::*;
#(
    parameter int OFFSET = 16,
    parameter int LO     = 16,
    parameter int HI     = 235
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic [7:0]              result
);

    localparam logic signed [SUM_W-1:0] OFFSET_S = SUM_W'(OFFSET);
    localparam logic signed [SUM_W-1:0] LO_S     = SUM_W'(LO);
    localparam logic signed [SUM_W-1:0] HI_S     = SUM_W'(HI);

    logic signed [SUM_W-1:0] offset_val;

    assign offset_val = (sum >>> 8) + OFFSET_S;

    always_comb begin
        result = offset_val[7:0];
        if (offset_val < LO_S)
            result = LO_S[7:0];
        else if (offset_val > HI_S)
            result = HI_S[7:0];
    end

endmodule

// File: rtl/rgb_to_ycbcr.sv
// Four-stage BT.601 RGB -> YCbCr converter with 4:4:4 outputs and a co-sited
// 4:2:2 chroma stream (Cb on even pixels, held Cr on odd pixels).
module rgb_to_ycbcr
    import video_color_pkg::*;
#(
    parameter bit CLAMP_STUDIO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sol,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       out_valid,
    output logic       out_sol,
    output logic [7:0] y,
    output logic [7:0] cb,
    output logic [7:0] cr,
    output logic [7:0] c422,
    output logic       c422_is_cr
);

    logic s1_valid_reg, s1_sol_reg;
    logic s2_valid_reg, s2_sol_reg;
    logic s3_valid_reg, s3_sol_reg;

    logic [7:0]              in_pix     [3];
    logic [7:0]              s1_pix_reg [3];
    logic signed [SUM_W-1:0] prod_next  [9];
    logic signed [SUM_W-1:0] prod_reg   [9];
    logic signed [SUM_W-1:0] sum_next   [3];
    logic signed [SUM_W-1:0] sum_reg    [3];
    logic [7:0]              clamp_out  [3];

    logic       odd_next_reg;
    logic [7:0] cr_hold_reg;
    logic       pix_odd;

    assign in_pix[0] = red;
    assign in_pix[1] = green;
    assign in_pix[2] = blue;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign prod_next[gi] = SUM_W'($signed({1'b0, s1_pix_reg[gi % 3]})) * SUM_W'(COEF[gi]);
        end
        for (gi = 0; gi < 3; gi++) begin : g_comp
            assign sum_next[gi] = prod_reg[3*gi] + prod_reg[3*gi+1] + prod_reg[3*gi+2] + ROUND_BIAS;
            color_clamp8 #(
                .OFFSET(gi == 0 ? Y_OFFSET : C_OFFSET),
                .LO    (clamp_lo(CLAMP_STUDIO)),
                .HI    (clamp_hi(CLAMP_STUDIO, gi != 0))
            ) u_clamp (
                .sum   (sum_reg[gi]),
                .result(clamp_out[gi])
            );
        end
    endgenerate

    // Datapath registers only move with valid data, so idle outputs stay stable.
    always_ff @(posedge clk) begin
        if (in_valid)
            s1_pix_reg <= in_pix;
        if (s1_valid_reg)
            prod_reg <= prod_next;
        if (s2_valid_reg)
            sum_reg <= sum_next;
    end

    // A line start always restarts pairing on an even pixel.
    assign pix_odd = s3_sol_reg ? 1'b0 : odd_next_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sol_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_sol_reg   <= 1'b0;
            s3_valid_reg <= 1'b0;
            s3_sol_reg   <= 1'b0;
            out_valid    <= 1'b0;
            out_sol      <= 1'b0;
            y            <= 8'(Y_OFFSET);
            cb           <= 8'(C_OFFSET);
            cr           <= 8'(C_OFFSET);
            c422         <= 8'(C_OFFSET);
            c422_is_cr   <= 1'b0;
            odd_next_reg <= 1'b0;
            cr_hold_reg  <= 8'(C_OFFSET);
        end else begin
            s1_valid_reg <= in_valid;
            s1_sol_reg   <= in_valid & in_sol;
            s2_valid_reg <= s1_valid_reg;
            s2_sol_reg   <= s1_sol_reg;
            s3_valid_reg <= s2_valid_reg;
            s3_sol_reg   <= s2_sol_reg;
            out_valid    <= s3_valid_reg;
            out_sol      <= s3_sol_reg;
            if (s3_valid_reg) begin
                y            <= clamp_out[0];
                cb           <= clamp_out[1];
                cr           <= clamp_out[2];
                c422         <= pix_odd ? cr_hold_reg : clamp_out[1];
                c422_is_cr   <= pix_odd;
                odd_next_reg <= ~pix_odd;
                if (!pix_odd)
                    cr_hold_reg <= clamp_out[2];
            end
        end
    end

endmodule

// File: doc/rgb_to_ycbcr.md
RGB_TO_YCBCR -- requirements
Module: rgb_to_ycbcr

Interface
REQ-001 SHALL have parameter: CLAMP_STUDIO, 1, 1 = clamp Y to 16..235 and Cb/Cr to 16..240; 0 = clamp all three to 0..255.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports in order:
clk  in  1  rising-edge clock for all state
rst  in  1  synchronous active-high reset
in_valid  in  1  red/green/blue/in_sol valid this cycle
in_sol  in  1  start of line; qualified by in_valid
red  in  8  unsigned R
green  in  8  unsigned G
blue  in  8  unsigned B
out_valid  out  1  outputs valid this cycle
out_sol  out  1  start of line, aligned with out_valid
y  out  8  luma
cb  out  8  blue-difference chroma (4:4:4)
cr  out  8  red-difference chroma (4:4:4)
c422  out  8  co-sited 4:2:2 chroma sample
c422_is_cr  out  1  0 = c422 carries Cb, 1 = carries Cr

Function
REQ-003 SHALL compute BT.601 studio range: Y = 16 + ((66R + 129G + 25B + 128) >>> 8); Cb = 128 + ((-38R - 74G + 112B + 128) >>> 8); Cr = 128 + ((112R - 94G - 18B + 128) >>> 8); >>> is arithmetic shift (floor).
REQ-004 SHALL zero-extend inputs to 9-bit signed; coefficients 9-bit signed; products 18-bit signed; sums 18-bit signed (|sum| < 2^17 by construction).
REQ-005 SHALL pipeline in 4 register stages: S1 input capture, S2 nine products, S3 three sums incl. +128, S4 shift, offset, clamp; latency exactly 4 cycles in_valid -> out_valid.
REQ-006 SHALL advance every cycle, no stall/backpressure; in_valid and in_sol propagate alongside data; bubbles preserved.
REQ-007 SHALL clamp per CLAMP_STUDIO after offset; clamp SHALL never fire for in-range inputs but remains required.
REQ-008 SHALL hold a phase bit: valid pixel with in_sol forces phase even; each other valid pixel toggles phase; invalid cycles leave phase unchanged; in_sol without in_valid ignored.
REQ-009 SHALL, on even-phase output pixel: c422 = that pixel's cb, c422_is_cr = 0, and store that pixel's cr in a hold register.
REQ-010 SHALL, on odd-phase output pixel: c422 = held cr from preceding even pixel, c422_is_cr = 1; odd pixel's own cb/cr not used for c422.
REQ-011 SHALL, for odd-length lines, emit last pixel as even phase; next in_sol restarts pairing; no flush pixel generated.
REQ-012 SHALL leave y/cb/cr/c422/c422_is_cr undefined-but-stable (don't care) when out_valid = 0; out_sol = 0 whenever out_valid = 0.

Reset
REQ-013 SHALL, on rst, clear all pipeline valid and sol bits, phase to even, cr hold to 8'h80 within the same edge.
REQ-014 SHALL drive out_valid = 0, out_sol = 0, y = 8'h10, cb = cr = c422 = 8'h80, c422_is_cr = 0 after reset.
REQ-015 SHALL discard pixels in flight on mid-stream rst; first out_valid after release appears 4 cycles after first post-reset in_valid.
REQ-016 SHALL treat the first valid pixel after reset as even phase even without in_sol.

Structure
REQ-017 SHALL place nine coefficients, BT.601 offsets (16, 128), clamp limits and latency constant (4) in shared package video_color_pkg, also used by ycbcr_to_rgb-side logic.
REQ-018 SHALL use one sub-module, color_clamp8 (18-bit sum in, shift/offset/clamp, 8-bit out), instantiated three times.

Verification
REQ-019 Black: R,G,B = 0,0,0 -> Y=16, Cb=128, Cr=128, out_valid exactly 4 cycles after in_valid.
REQ-020 White: 255,255,255 -> Y=235, Cb=128, Cr=128; Red 255,0,0 -> 82,90,240; Blue 0,0,255 -> 41,240,110; Green 0,255,0 -> Cb=54.
REQ-021 4:2:2: in_sol+red then blue -> c422 = 90 (is_cr 0), then 240 (is_cr 1); 3-pixel line then in_sol -> third pixel even, next line restarts even.
REQ-022 Bubbles: valid pixels separated by 0-3 idle cycles -> out_valid pattern identical, delayed 4; phase toggles only on valid pixels.
REQ-023 Reset mid-stream: rst asserted with 3 pixels in flight -> no out_valid for them; outputs at REQ-014 values; next pixel even phase.
REQ-024 Exhaustive sweep vs. reference model, both CLAMP_STUDIO values -> bit-exact y/cb/cr, all within clamp limits.
